// File: rtl/gtf_link_seq_pkg.sv
// Shared types and constants for the GTF reset/link sequencer.
// Holds state encodings, pulse width and a counter-width helper.
package gtf_link_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        WAIT_DP   = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        DP_RST    = 2'd0,
        WAIT_LINK = 2'd1,
        STABLE    = 2'd2,
        FAILED    = 2'd3
    } ch_state_e;

    localparam int unsigned PULSE_W = 5;
    localparam logic [PULSE_W-1:0] PULSE_LOAD = 5'h1F;
    localparam int unsigned RETRY_W = 3;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gtf_ch_link_mon.sv
// Per-channel link monitor: datapath reset, stability and retry FSM.
// GTF_RX_ONLY_RETRY_EN: retries and FAILED drive only the RX reset.
module gtf_ch_link_mon
    import gtf_link_seq_pkg::*;
#(
    parameter int unsigned STABLE_CNT   = 2048,
    parameter int unsigned LINK_TIMEOUT = 1048576,
    parameter int unsigned RETRY_PULSE  = 16,
    parameter int unsigned MAX_RETRY    = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr_sticky,
    input  logic               link_status_in,
    output logic               txdp_reset_out,
    output logic               rxdp_reset_out,
    output logic               link_stable_out,
    output logic               pulse_out,
    output logic               ch_failed_out,
    output logic [RETRY_W-1:0] retry_cnt_out
);

    localparam int unsigned TO_W = cnt_w(LINK_TIMEOUT);
    localparam int unsigned UP_W = cnt_w(STABLE_CNT);
    localparam int unsigned PC_W = cnt_w(RETRY_PULSE);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LINK_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [UP_W-1:0] UP_LAST = UP_W'(STABLE_CNT - 1);
    localparam logic [UP_W-1:0] UP_ONE  = UP_W'(1);
    localparam logic [PC_W-1:0] PC_LOAD = PC_W'(RETRY_PULSE - 1);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
    localparam logic [RETRY_W-1:0] RT_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RT_ONE = RETRY_W'(1);

    logic [1:0]         lsync_q;
    logic               link;
    ch_state_e          state_q, state_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [UP_W-1:0]    up_q, up_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               stable_q, stable_d;
    logic               stable_prev_q;
    logic [PULSE_W-1:0] sh_q, sh_d;
    logic               failed_q, failed_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               dp_rst;

    assign link = lsync_q[1];

    // Two-flop synchroniser for the asynchronous link status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsync_q <= 2'b00;
        end else begin
            lsync_q <= {lsync_q[0], link_status_in};
        end
    end

    // Channel FSM, counters and the stable-rise pulse shifter.
    always_comb begin
        state_d  = state_q;
        to_d     = to_q;
        up_d     = up_q;
        pc_d     = pc_q;
        stable_d = stable_q;
        failed_d = failed_q;
        retry_d  = retry_q;
        sh_d     = {sh_q[PULSE_W-2:0], 1'b0};
        if (stable_q && !stable_prev_q) begin
            sh_d = PULSE_LOAD;
        end
        if (!en) begin
            state_d  = DP_RST;
            to_d     = '0;
            up_d     = '0;
            pc_d     = '0;
            stable_d = 1'b0;
            sh_d     = '0;
        end else begin
            unique case (state_q)
                DP_RST: begin
                    if (pc_q == '0) begin
                        state_d = WAIT_LINK;
                        to_d    = '0;
                        up_d    = '0;
                    end else begin
                        pc_d = pc_q - PC_ONE;
                    end
                end
                WAIT_LINK: begin
                    if (to_q != '1) begin
                        to_d = to_q + TO_ONE;
                    end
                    if (link) begin
                        if (up_q != '1) begin
                            up_d = up_q + UP_ONE;
                        end
                    end else begin
                        up_d = '0;
                    end
                    if (link && up_q == UP_LAST) begin
                        state_d  = STABLE;
                        stable_d = 1'b1;
                    end else if (to_q == TO_LAST) begin
                        if (retry_q < RT_MAX) begin
                            retry_d = retry_q + RT_ONE;
                            state_d = DP_RST;
                            pc_d    = PC_LOAD;
                        end else begin
                            state_d  = FAILED;
                            failed_d = 1'b1;
                        end
                    end
                end
                STABLE: begin
                    if (!link) begin
                        state_d  = WAIT_LINK;
                        stable_d = 1'b0;
                        to_d     = '0;
                        up_d     = '0;
                    end
                end
                FAILED: begin
                    failed_d = 1'b1;
                end
                default: begin
                    state_d = DP_RST;
                end
            endcase
        end
        if (clr_sticky) begin
            failed_d = 1'b0;
            retry_d  = '0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= DP_RST;
            to_q          <= '0;
            up_q          <= '0;
            pc_q          <= '0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            sh_q          <= '0;
            failed_q      <= 1'b0;
            retry_q       <= '0;
        end else begin
            state_q       <= state_d;
            to_q          <= to_d;
            up_q          <= up_d;
            pc_q          <= pc_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            sh_q          <= sh_d;
            failed_q      <= failed_d;
            retry_q       <= retry_d;
        end
    end

    assign dp_rst = !en || state_q == DP_RST || state_q == FAILED;

`ifdef GTF_RX_ONLY_RETRY_EN
    logic released_q, released_d;

    // TX stays released once the first release has happened.
    always_comb begin
        released_d = en && (released_q || (state_q == DP_RST && pc_q == '0));
    end

    // Release flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            released_q <= 1'b0;
        end else begin
            released_q <= released_d;
        end
    end

    assign txdp_reset_out = !en || !released_q;
    assign rxdp_reset_out = dp_rst;
`else
    assign txdp_reset_out = dp_rst;
    assign rxdp_reset_out = dp_rst;
`endif

    assign link_stable_out = stable_q;
    assign pulse_out       = sh_q[PULSE_W-1];
    assign ch_failed_out   = failed_q;
    assign retry_cnt_out   = retry_q;

endmodule

// File: rtl/gtf_link_reset_seq.sv
// Reset and link sequencer: lock qualification and global reset FSM.
// GTF_RX_ONLY_RETRY_EN is forwarded to the per-channel monitors.
module gtf_link_reset_seq
    import gtf_link_seq_pkg::*;
#(
    parameter int unsigned NUM_CHANNEL  = 1,
    parameter int unsigned LOCK_DLY     = 100,
    parameter int unsigned DP_DLY       = 1000,
    parameter int unsigned STABLE_CNT   = 2048,
    parameter int unsigned LINK_TIMEOUT = 1048576,
    parameter int unsigned RETRY_PULSE  = 16,
    parameter int unsigned MAX_RETRY    = 7
) (
    input  logic                     gtf_freerun_clk,
    input  logic                     sys_if_rstn,
    input  logic                     clk_wiz_locked,
    input  logic                     sys_gtf_resetn,
    input  logic [NUM_CHANNEL-1:0]   link_status_in,
    output logic                     reset_all_out,
    output logic [NUM_CHANNEL-1:0]   txdp_reset_out,
    output logic [NUM_CHANNEL-1:0]   rxdp_reset_out,
    output logic [NUM_CHANNEL-1:0]   link_stable_out,
    output logic [NUM_CHANNEL-1:0]   link_down_latched_reset_out,
    output logic [NUM_CHANNEL-1:0]   ch_failed_out,
    output logic [3*NUM_CHANNEL-1:0] retry_cnt_out,
    output logic [1:0]               seq_state_out
);

    localparam int unsigned G_MAX = (LOCK_DLY > DP_DLY) ? LOCK_DLY : DP_DLY;
    localparam int unsigned G_W   = cnt_w(G_MAX);

    localparam logic [G_W-1:0] LOCK_LOAD = G_W'(LOCK_DLY - 1);
    localparam logic [G_W-1:0] DP_LOAD   = G_W'(DP_DLY - 1);
    localparam logic [G_W-1:0] G_ONE     = G_W'(1);

    logic [1:0]     lock_sync_q;
    logic           abort;
    logic           ch_en;
    seq_state_e     state_q, state_d;
    logic [G_W-1:0] cnt_q, cnt_d;

    assign abort = !lock_sync_q[1] || !sys_gtf_resetn;
    assign ch_en = (state_q == RUN) && !abort;

    // Two-flop synchroniser for the clock-wizard lock.
    always_ff @(posedge gtf_freerun_clk or negedge sys_if_rstn) begin
        if (!sys_if_rstn) begin
            lock_sync_q <= 2'b00;
        end else begin
            lock_sync_q <= {lock_sync_q[0], clk_wiz_locked};
        end
    end

    // Global sequence: lock hold-off, reset_all release, datapath delay.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = WAIT_LOCK;
            cnt_d   = LOCK_LOAD;
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    if (cnt_q == '0) begin
                        state_d = WAIT_DP;
                        cnt_d   = DP_LOAD;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = cnt_q - G_ONE;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = WAIT_DP;
                        cnt_d   = DP_LOAD;
                    end else begin
                        cnt_d = cnt_q - G_ONE;
                    end
                end
                WAIT_DP: begin
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - G_ONE;
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = LOCK_LOAD;
                end
            endcase
        end
    end

    // Global state registers.
    always_ff @(posedge gtf_freerun_clk or negedge sys_if_rstn) begin
        if (!sys_if_rstn) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= LOCK_LOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign reset_all_out = abort || state_q == WAIT_LOCK || state_q == HOLD;
    assign seq_state_out = state_q;

    for (genvar i = 0; i < NUM_CHANNEL; i++) begin : g_ch
        gtf_ch_link_mon #(
            .STABLE_CNT   (STABLE_CNT),
            .LINK_TIMEOUT (LINK_TIMEOUT),
            .RETRY_PULSE  (RETRY_PULSE),
            .MAX_RETRY    (MAX_RETRY)
        ) u_mon (
            .clk             (gtf_freerun_clk),
            .rst_n           (sys_if_rstn),
            .en              (ch_en),
            .clr_sticky      (!sys_gtf_resetn),
            .link_status_in  (link_status_in[i]),
            .txdp_reset_out  (txdp_reset_out[i]),
            .rxdp_reset_out  (rxdp_reset_out[i]),
            .link_stable_out (link_stable_out[i]),
            .pulse_out       (link_down_latched_reset_out[i]),
            .ch_failed_out   (ch_failed_out[i]),
            .retry_cnt_out   (retry_cnt_out[3*i +: 3])
        );
    end

endmodule

// File: doc/gtf_link_reset_seq.md
Name: gtf_link_reset_seq

Overview:
- Reset and link sequencer for the GTF raw channel wrapper; replaces free-running reset timers with an explicit controller.
- Qualifies clock-wizard lock, then drives the wizard-wide reset. Next it releases the per-channel TX/RX datapath resets.
- Monitors each channel's link status and declares the link stable. Retries a channel's datapath reset on link timeout.
- Sits between the clock/reset inputs and the GTF example top; runs on the 200 MHz free-running clock.

Parameters:
- NUM_CHANNEL, 1, number of GTF channels.
- LOCK_DLY, 100, cycles of qualified lock before reset_all is released.
- DP_DLY, 1000, cycles after reset_all release before datapath resets are released.
- STABLE_CNT, 2048, consecutive link-up cycles needed to declare a link stable.
- LINK_TIMEOUT, 1048576, cycles allowed in WAIT_LINK before a retry.
- RETRY_PULSE, 16, width of the datapath reset pulse on a retry.
- MAX_RETRY, 7, number of retries before a channel goes FAILED (3-bit counter).

Ports:
- gtf_freerun_clk  in  1  sole clock.
- sys_if_rstn  in  1  asynchronous active-low reset.
- clk_wiz_locked  in  1  asynchronous; synchronised internally with 2 flops.
- sys_gtf_resetn  in  1  synchronous active-low soft reset; restarts the sequence from WAIT_LOCK.
- link_status_in  in  NUM_CHANNEL  per-channel link up; asynchronous; 2-flop synchronised.
- reset_all_out  out  1  active-high wizard reset.
- txdp_reset_out  out  NUM_CHANNEL  active-high TX datapath reset.
- rxdp_reset_out  out  NUM_CHANNEL  active-high RX datapath reset.
- link_stable_out  out  NUM_CHANNEL  link declared stable.
- link_down_latched_reset_out  out  NUM_CHANNEL  5-cycle pulse on the rising edge of link_stable.
- ch_failed_out  out  NUM_CHANNEL  sticky; retries exhausted.
- retry_cnt_out  out  3*NUM_CHANNEL  retry count per channel, channel i at bits [3i+2:3i].
- seq_state_out  out  2  global state encoding.

Behaviour:
- Reset values while sys_if_rstn=0:
  - reset_all_out=1, txdp/rxdp_reset_out all 1.
  - link_stable_out, link_down_latched_reset_out, ch_failed_out, retry_cnt_out = 0.
  - seq_state_out=WAIT_LOCK.
- Global FSM states:
  - WAIT_LOCK(0): load counter with LOCK_DLY-1. Go to HOLD when synced lock=1.
  - HOLD(1): count down. Synced lock=0 returns to WAIT_LOCK. At 0, deassert reset_all_out on the next edge and go to WAIT_DP.
  - WAIT_DP(2): count DP_DLY-1 down to 0, then go to RUN.
  - RUN(3): per-channel FSMs are enabled.
- Lock loss in any state → WAIT_LOCK. This reasserts reset_all_out and all datapath resets the same cycle, and clears per-channel state, but **not** ch_failed_out or retry_cnt_out.
- sys_gtf_resetn=0: same as lock loss, and additionally clears ch_failed_out and retry_cnt_out.
- Release latency: reset_all_out falls exactly LOCK_DLY cycles after the synced lock rises.
- Per-channel FSM states: DP_RST, WAIT_LINK, STABLE, FAILED.
  - DP_RST: datapath resets =1. On entry from RUN, exit after 1 cycle. On entry from a retry, exit after RETRY_PULSE cycles. Next state WAIT_LINK with resets=0.
  - WAIT_LINK: timeout counter increments every cycle; up counter increments while link=1 and clears while link=0.
  - WAIT_LINK, up counter reaches STABLE_CNT-1 with link=1 → STABLE. link_stable_out=1 on that edge; pulse starts the next cycle.
  - WAIT_LINK, timeout counter reaches LINK_TIMEOUT-1:
    - retry_cnt < MAX_RETRY → increment retry_cnt, go to DP_RST.
    - otherwise → FAILED.
  - Simultaneous stable and timeout: stable wins.
  - STABLE: synced link=0 → clear link_stable_out the next edge and go to WAIT_LINK with both counters cleared. No datapath reset is applied.
  - FAILED: resets held 1, ch_failed_out=1. Exit only via sys_gtf_resetn or lock loss.
- Counter widths:
  - $clog2(max(LOCK_DLY, DP_DLY)) for the global counter.
  - $clog2(LINK_TIMEOUT) for the timeout counter.
  - $clog2(STABLE_CNT) for the up counter.
  - All counters saturate; none wrap.
- retry_cnt saturates at MAX_RETRY.
- link_down_latched_reset_out: 5-bit shift register loaded with 5'h1F on the link_stable rising edge and drained MSB-first.

Optional Feature:
- Macro: GTF_RX_ONLY_RETRY_EN.
- Defined: retry pulses assert only rxdp_reset_out for that channel; txdp_reset_out stays 0 once first released, and FAILED holds only rxdp_reset_out=1.
- Undefined: retries and FAILED drive both TX and RX resets.
- The initial release and global resets are identical in both builds.

Decomposition:
- Package gtf_link_seq_pkg:
  - global state enum (WAIT_LOCK, HOLD, WAIT_DP, RUN);
  - channel state enum (DP_RST, WAIT_LINK, STABLE, FAILED);
  - pulse width constant 5.
- Sub-module gtf_ch_link_mon: one instance per channel via generate; contains the channel FSM, counters, the link synchroniser and the pulse shifter.
- The top level holds the lock synchroniser and the global FSM.

Test Plan:
- Power-up with lock raised at t0 → reset_all_out falls at t0+100+2 sync cycles; dp resets fall 1000+1 cycles later; seq_state_out=3.
- link_status_in held 1 from dp release → link_stable_out rises after 2048 cycles; link_down_latched_reset_out high exactly 5 cycles.
- link held 0, LINK_TIMEOUT reduced to 64 → 16-cycle dp reset pulses, retry_cnt 1..7; after the 8th timeout, ch_failed_out=1 and resets held high.
- Link drop for 1 cycle in STABLE → link_stable_out=0 next cycle; no dp reset pulse; re-stable after 2048 up cycles.
- Lock drop mid-RUN → reset_all_out and dp resets =1 the same cycle; ch_failed_out is preserved. sys_gtf_resetn pulse → ch_failed_out and retry_cnt_out cleared.
- With GTF_RX_ONLY_RETRY_EN, timeout retry → rxdp pulse of 16 cycles; txdp_reset_out stays 0 throughout.
